demux_1_2_4_driver: RTL and testbench
=====================================

# demux_1_2_4_driver

Upstream sequencing stage for the 1-to-4 demultiplexer. Accepts single-bit data items over a valid/ready handshake and chooses a destination channel, either from the item's destination field or from an internal round-robin pointer. It drives the demux data input (`in`) and select (`S`) for a fixed number of hold cycles, then inserts one idle gap cycle. It also keeps a saturating transfer count for each channel.

## Interface
- `HOLD_CYCLES`, default 2: cycles each accepted item is presented on `out_in`/`out_S`; legal range ≥1.
- `CNT_W`, default 8: width of each per-channel transfer counter.
- `clk`  input  1  single clock, rising-edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  upstream item valid.
- `in_ready`  output  1  block can accept an item.
- `in_data`  input  1  data bit to route.
- `in_dest`  input  2  destination channel, 0–3; ignored when `rr_mode`=1.
- `rr_mode`  input  1  1 = round-robin destination, 0 = use `in_dest`; sampled at accept.
- `clr_cnt`  input  1  synchronous clear of all channel counters.
- `out_in`  output  1  drives the demux `in`.
- `out_S`  output  2  drives the demux `S`.
- `busy`  output  1  high in DRIVE or GAP.
- `cnt`  output  4*CNT_W  per-channel counts; channel n occupies bits [n*CNT_W +: CNT_W].

## Operation
- States:
  - IDLE: `in_ready`=1, `out_in`=0, `out_S` holds its last value.
  - DRIVE: `out_in`=data_reg, `out_S`=sel_reg.
  - GAP: `out_in`=0, `out_S`=sel_reg.
- Accept occurs when `in_valid` & `in_ready` at a rising edge. On accept:
  - data_reg ← `in_data`.
  - sel_reg ← `rr_mode` ? rr_ptr : `in_dest`.
  - hold_cnt ← HOLD_CYCLES−1.
  - Go to DRIVE.
- DRIVE: if hold_cnt==0, go to GAP; otherwise decrement hold_cnt.
- GAP: always one cycle, then IDLE.
- `in_ready` = (state==IDLE) & `rst_n`. It is never asserted in DRIVE or GAP.
- rr_ptr is 2 bits. It advances only on an accept made with `rr_mode`=1 and wraps 3→0. It is not touched by accepts with `rr_mode`=0.
- Counters:
  - On accept, `cnt[sel]` increments, where sel is the value loaded into sel_reg.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - `clr_cnt` zeroes all four counters. If a clear and an increment occur in the same cycle, the clear wins.
- `clr_cnt` has no effect on the FSM, rr_ptr, or outputs other than `cnt`.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). The item in flight is dropped and not retried.

## Timing
- Reset values:
  - state=IDLE, `out_in`=0, `out_S`=2'b00, `busy`=0.
  - `in_ready`=0 while `rst_n` is low, 1 after release.
  - rr_ptr=0, all `cnt`=0, data_reg=0, sel_reg=0.
- Accept at edge k:
  - `out_in`/`out_S` show the item during cycles k+1 … k+HOLD_CYCLES.
  - GAP is cycle k+HOLD_CYCLES+1.
  - `in_ready` is high again in cycle k+HOLD_CYCLES+2.
- Throughput is one item per HOLD_CYCLES+2 cycles.
- The counter update is visible on `cnt` from cycle k+1.
- All outputs are registered except `in_ready` and `busy`, which decode directly from state.
- Upstream must hold `in_data`/`in_dest` stable only in the accept cycle.

## Structure
- Shared package `demux_pkg`:
  - State enum `drv_state_t` {IDLE, DRIVE, GAP}.
  - `NUM_CH`=4.
  - `SEL_W`=2.
- One natural sub-module: `sat_counter` (CNT_W-wide, inc/clr, clear priority), instantiated four times.
- Everything else is flat: the FSM, hold counter, rr_ptr and output registers.

## Test plan
- Reset then a single item, with HOLD_CYCLES=2, `rr_mode`=0, `in_dest`=2, `in_data`=1:
  - `out_S`=2'b10 and `out_in`=1 for 2 cycles, then `out_in`=0 for 1 cycle.
  - `in_ready` returns after 4 cycles.
  - cnt[2]=1, other counters 0.
- `rr_mode`=1 with 5 back-to-back items:
  - `out_S` sequence is 0,1,2,3,0.
  - cnt = {1,1,1,2} for channels 3..0 (cnt[0]=2, others 1).
  - rr_ptr ends at 1.
- Data 0 routed to dest 3: `out_S`=3 and `out_in`=0 throughout DRIVE; cnt[3] still increments.
- Saturation, with CNT_W=2: 5 accepts to channel 1 leave cnt[1]=3; assert `clr_cnt` in the same cycle as a 6th accept → cnt[1]=0.
- `in_valid` held high continuously: exactly one accept per HOLD_CYCLES+2 cycles, and `in_ready`=0 in every DRIVE and GAP cycle.
- `rst_n` pulsed low during DRIVE:
  - Outputs immediately go to 0 / 2'b00 and counters to 0.
  - After release, `in_ready`=1 and the next item routes normally.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : demux_pkg                                                         |
// | Brief  : Shared types and constants for the 1-to-4 demux driver.           |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } drv_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1_2_4_driver_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sat_counter                                                       |
// | Brief  : Saturating up-counter; a clear takes priority over an increment.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/demux_1_2_4_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : demux_1_2_4_driver                                                |
// | Brief  : Sequences items onto the 1-to-4 demux in/S pins with a hold       |
// |          period and idle gap, and counts transfers per channel.            |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module demux_1_2_4_driver
    import demux_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_data,
    input  logic [SEL_W-1:0]      in_dest,
    input  logic                  rr_mode,
    input  logic                  clr_cnt,
    output logic                  out_in,
    output logic [SEL_W-1:0]      out_S,
    output logic                  busy,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    localparam int                  c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(HOLD_CYCLES - 1);

    drv_state_t          r_state;
    logic [c_hold_w-1:0] r_hold;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic                r_out_in;

    logic                w_accept;
    logic [SEL_W-1:0]    w_sel;
    logic [NUM_CH-1:0]   w_inc;

    assign in_ready = (r_state == IDLE) & rst_n;
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid & in_ready;
    assign w_sel    = rr_mode ? r_rr_ptr : in_dest;

    // r_out_in doubles as the data register: it carries the item during
    // DRIVE and is forced low on the way into GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_out_in <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= DRIVE;
                        r_hold   <= c_hold_init;
                        r_sel    <= w_sel;
                        r_out_in <= in_data;
                        if (rr_mode) begin
                            r_rr_ptr <= r_rr_ptr + 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (r_hold == '0) begin
                        r_state  <= GAP;
                        r_out_in <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_out_in <= 1'b0;
                end
            endcase
        end
    end

    assign out_in = r_out_in;
    assign out_S  = r_sel;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_inc[i] = w_accept & (w_sel == SEL_W'(i));

            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (w_inc[i]),
                .clr   (clr_cnt),
                .count (cnt[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule : demux_1_2_4_driver
`default_nettype wire

// File: tb/tb_demux_1_2_4_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_demux_1_2_4_driver                                             |
// | Brief  : Scoreboard bench for demux_1_2_4_driver (HOLD_CYCLES=2, CNT_W=2). |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_demux_1_2_4_driver;

    localparam int HOLD  = 2;
    localparam int CW    = 2;
    localparam int SATV  = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_data  = 1'b0;
    logic [1:0]    in_dest  = 2'd0;
    logic          rr_mode  = 1'b0;
    logic          clr_cnt  = 1'b0;
    logic          in_ready;
    logic          out_in;
    logic [1:0]    out_S;
    logic          busy;
    logic [4*CW-1:0] cnt;

    typedef struct packed {
        logic       d;
        logic [1:0] s;
    } item_t;

    item_t      sb[$];
    int         exp_cnt[4];
    logic [1:0] exp_rr;
    int         compares = 0;
    int         fails    = 0;

    demux_1_2_4_driver #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .rr_mode  (rr_mode),
        .clr_cnt  (clr_cnt),
        .out_in   (out_in),
        .out_S    (out_S),
        .busy     (busy),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [4*CW-1:0] exp_cnt_vec();
        logic [4*CW-1:0] v;
        int              c;
        for (int n = 0; n < 4; n++) begin
            c = exp_cnt[n];
            v[n*CW +: CW] = c[CW-1:0];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
        exp_rr = 2'd0;
        sb.delete();
    endtask

    // Presents one item, waits (bounded) for acceptance, records the expectation.
    task automatic accept_item(input logic d, input logic [1:0] dest, input logic rr, input logic clr);
        int         waited;
        logic [1:0] sel;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dest;
        rr_mode  = rr;
        clr_cnt  = clr;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        compares++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        sel = rr ? exp_rr : dest;
        if (rr) exp_rr = exp_rr + 2'd1;
        if (clr) begin
            for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
        end else if (exp_cnt[sel] < SATV) begin
            exp_cnt[sel]++;
        end
        sb.push_back(item_t'{d, sel});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        in_data  = ~d;
        in_dest  = ~dest;
    endtask

    // Called on the first negedge after acceptance; checks DRIVE, GAP and return to IDLE.
    task automatic drain_item(input string tag);
        item_t    it;
        logic [4:0] exp;
        logic [4:0] obs;
        compares++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_scoreboard: queue size 0, required >0", tag);
            return;
        end
        it = sb.pop_front();
        compares++;
        if (cnt !== exp_cnt_vec()) begin
            fails++;
            $display("FAIL %s_cnt: cnt=%h required %h", tag, cnt, exp_cnt_vec());
        end
        for (int h = 0; h < HOLD; h++) begin
            obs = {out_in, out_S, busy, in_ready};
            exp = {it.d, it.s, 1'b1, 1'b0};
            compares++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s_drive%0d: {out_in,out_S,busy,in_ready}=%b required %b", tag, h, obs, exp);
            end
            @(negedge clk);
        end
        obs = {out_in, out_S, busy, in_ready};
        exp = {1'b0, it.s, 1'b1, 1'b0};
        compares++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s_gap: {out_in,out_S,busy,in_ready}=%b required %b", tag, obs, exp);
        end
        @(negedge clk);
        obs = {out_in, out_S, busy, in_ready};
        exp = {1'b0, it.s, 1'b0, 1'b1};
        compares++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s_idle: {out_in,out_S,busy,in_ready}=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b0;
        for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
        compares++;
        if (cnt !== '0) begin
            fails++;
            $display("FAIL clear: cnt=%h required 0", cnt);
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {out_in, out_S, busy, in_ready};
        compares++;
        if (obs !== 5'b0 || cnt !== '0) begin
            fails++;
            $display("FAIL reset_hold: outs=%b cnt=%h required 00000 / 0", obs, cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compares++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single();
        accept_item(1'b1, 2'd2, 1'b0, 1'b0);
        drain_item("single");
    endtask

    task automatic test_back_to_back_rr();
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            accept_item(i[0], 2'd3, 1'b1, 1'b0);
            drain_item("rr");
        end
        compares++;
        if (cnt !== {2'd1, 2'd1, 2'd1, 2'd2}) begin
            fails++;
            $display("FAIL rr_counts: cnt=%h required %h", cnt, {2'd1, 2'd1, 2'd1, 2'd2});
        end
        // Pointer should now sit at 1; in_dest=3 must be ignored.
        accept_item(1'b1, 2'd3, 1'b1, 1'b0);
        drain_item("rr_ptr");
    endtask

    task automatic test_data_zero();
        accept_item(1'b0, 2'd3, 1'b0, 1'b0);
        drain_item("data0");
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            accept_item(1'b1, 2'd1, 1'b0, 1'b0);
            drain_item("sat");
        end
        compares++;
        if (cnt[CW +: CW] !== 2'd3) begin
            fails++;
            $display("FAIL sat_value: cnt1=%0d required 3", cnt[CW +: CW]);
        end
        accept_item(1'b1, 2'd1, 1'b0, 1'b1);
        drain_item("sat_clr");
    endtask

    task automatic test_continuous_valid();
        int accepts;
        accepts  = 0;
        clear_counters();
        in_valid = 1'b1;
        in_data  = 1'b1;
        in_dest  = 2'd2;
        rr_mode  = 1'b0;
        for (int i = 0; i < 3 * (HOLD + 2); i++) begin
            if (in_valid && in_ready) accepts++;
            if (busy) begin
                compares++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL cont_ready_busy: in_ready=%b required 0 at cycle %0d", in_ready, i);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_cnt[2] = 3;
        compares++;
        if (accepts !== 3) begin
            fails++;
            $display("FAIL cont_accepts: accepts=%0d required 3", accepts);
        end
        compares++;
        if (cnt !== exp_cnt_vec()) begin
            fails++;
            $display("FAIL cont_cnt: cnt=%h required %h", cnt, exp_cnt_vec());
        end
    endtask

    task automatic test_reset_mid_drive();
        logic [4:0] obs;
        accept_item(1'b1, 2'd3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        obs = {out_in, out_S, busy, in_ready};
        compares++;
        if (obs !== 5'b0 || cnt !== '0) begin
            fails++;
            $display("FAIL midrst_async: outs=%b cnt=%h required 00000 / 0", obs, cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compares++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        accept_item(1'b1, 2'd2, 1'b1, 1'b0);
        drain_item("post_rst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back_rr();
        test_data_zero();
        test_saturation();
        test_continuous_valid();
        test_reset_mid_drive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule : tb_demux_1_2_4_driver
`default_nettype wire
